// File: rtl/tc_intersection_model_pkg.sv
`default_nettype none
// ============================================================================
//  Package : tc_pkg
//  Shared light encodings, street states and light-decoding helpers for the
//  intersection model.
//  Revision: 1.0 - initial release
// ============================================================================
package tc_pkg;

  // One-hot light codes driven by the traffic-light controller
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b100;

  // Per-street traffic flow state
  typedef enum logic {
    ST_STOP = 1'b0,
    ST_GO   = 1'b1
  } street_state_t;

  // True when cars may move on this light (yellow only if allowed)
  function automatic logic light_is_go(input logic [2:0] light,
                                       input logic       yellow_pass);
    return (light == LIGHT_GREEN) || (yellow_pass && (light == LIGHT_YELLOW));
  endfunction

  // True for green or yellow; illegal codes do not count as non-red
  function automatic logic light_not_red(input logic [2:0] light);
    return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW);
  endfunction

  // True only for the three legal one-hot codes
  function automatic logic light_legal(input logic [2:0] light);
    return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW) ||
           (light == LIGHT_RED);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_intersection_model_street_queue.sv
`default_nettype none
// ============================================================================
//  Module  : tc_street_queue
//  One street of the intersection: STOP/GO state registered from the light,
//  a pace counter spacing departures PASS_CYCLES apart, a saturating car
//  queue, a departure pulse and a sticky overflow flag.
//  Revision: 1.0 - initial release
// ============================================================================
module tc_street_queue
  import tc_pkg::*;
#(
  parameter int QDEPTH_W    = 4,
  parameter int PASS_CYCLES = 2,
  parameter int YELLOW_PASS = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arr,
  input  logic [2:0]          light,
  output logic                sensor,
  output logic [QDEPTH_W-1:0] q,
  output logic                dep,
  output logic                ovf
);

  localparam logic [QDEPTH_W-1:0] Q_MAX     = '1;
  localparam logic [QDEPTH_W-1:0] Q_ONE     = QDEPTH_W'(1);
  localparam logic [3:0]          PACE_LAST = 4'(PASS_CYCLES - 1);
  localparam logic                YP        = (YELLOW_PASS != 0);

  street_state_t state;
  street_state_t state_next;
  logic [3:0]    pace;
  logic          eligible;
  logic          depart;
  logic          drop;

  // Next state follows the currently sampled light; illegal codes mean STOP
  always_comb begin
    state_next = ST_STOP;
    if (light_is_go(light, YP)) begin
      state_next = ST_GO;
    end
  end

  // State register: GO becomes visible one cycle after the light changes
  always_ff @(posedge clk) begin
    if (rst) state <= ST_STOP;
    else     state <= state_next;
  end

  // A car can only be leaving while moving and someone is waiting
  assign eligible = (state == ST_GO) && (q != '0);
  assign depart   = eligible && (pace == PACE_LAST);
  // Only an arrival that cannot be absorbed by a simultaneous departure is lost
  assign drop     = arr && !depart && (q == Q_MAX);

  // Pace counter: counts GO cycles toward the next departure
  always_ff @(posedge clk) begin
    if (rst || !eligible || depart) pace <= '0;
    else                            pace <= pace + 4'd1;
  end

  // Queue counter: saturates at full, never wraps below zero
  always_ff @(posedge clk) begin
    if (rst)                                 q <= '0;
    else if (arr && !depart && q != Q_MAX)   q <= q + Q_ONE;
    else if (depart && !arr)                 q <= q - Q_ONE;
  end

  // Departure pulse and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      dep <= 1'b0;
      ovf <= 1'b0;
    end else begin
      dep <= depart;
      ovf <= ovf | drop;
    end
  end

  assign sensor = (q != '0);

endmodule
`default_nettype wire

// File: rtl/tc_intersection_model.sv
`default_nettype none
// ============================================================================
//  Module  : tc_intersection_model
//  Cycle-accurate intersection for a traffic-light controller: two
//  independent street queues fed by arrival pulses and drained by the lights,
//  producing the T_A/T_B traffic sensors.
//  Optional macro TC_INTERSECTION_CONFLICT_CHECK_EN adds a sticky CONFLICT
//  output flagging unsafe or illegal light combinations.
//  Revision: 1.0 - initial release
// ============================================================================
module tc_intersection_model
  import tc_pkg::*;
#(
  parameter int QDEPTH_W    = 4,
  parameter int PASS_CYCLES = 2,
  parameter int YELLOW_PASS = 0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                ARR_A,
  input  logic                ARR_B,
  input  logic [2:0]          L_A,
  input  logic [2:0]          L_B,
  output logic                T_A,
  output logic                T_B,
  output logic [QDEPTH_W-1:0] Q_A,
  output logic [QDEPTH_W-1:0] Q_B,
  output logic                DEP_A,
  output logic                DEP_B,
  output logic                OVF_A,
  output logic                OVF_B
`ifdef TC_INTERSECTION_CONFLICT_CHECK_EN
  ,
  output logic                CONFLICT
`endif
);

  tc_street_queue #(
    .QDEPTH_W    (QDEPTH_W),
    .PASS_CYCLES (PASS_CYCLES),
    .YELLOW_PASS (YELLOW_PASS)
  ) u_street_a (
    .clk    (CLK),
    .rst    (RESET),
    .arr    (ARR_A),
    .light  (L_A),
    .sensor (T_A),
    .q      (Q_A),
    .dep    (DEP_A),
    .ovf    (OVF_A)
  );

  tc_street_queue #(
    .QDEPTH_W    (QDEPTH_W),
    .PASS_CYCLES (PASS_CYCLES),
    .YELLOW_PASS (YELLOW_PASS)
  ) u_street_b (
    .clk    (CLK),
    .rst    (RESET),
    .arr    (ARR_B),
    .light  (L_B),
    .sensor (T_B),
    .q      (Q_B),
    .dep    (DEP_B),
    .ovf    (OVF_B)
  );

`ifdef TC_INTERSECTION_CONFLICT_CHECK_EN
  logic conflict;
  logic conflict_now;

  // Both streets moving at once, or any light not one-hot, is a conflict
  assign conflict_now = (light_not_red(L_A) && light_not_red(L_B)) ||
                        !light_legal(L_A) || !light_legal(L_B);

  // Sticky conflict flag, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RESET) conflict <= 1'b0;
    else       conflict <= conflict | conflict_now;
  end

  assign CONFLICT = conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tc_intersection_model.sv
`default_nettype none
// ============================================================================
//  Module  : tb_tc_intersection_model
//  Self-checking bench: two DUTs (4-bit queue / green-only and 2-bit queue /
//  yellow-pass) share stimulus; an arrival/streak model predicts every output
//  each cycle, and literal checks pin key points of the scenarios.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_tc_intersection_model;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       CLK = 1'b0;
  logic       RESET, ARR_A, ARR_B;
  logic [2:0] L_A, L_B;

  logic       t_a0, t_b0, dep_a0, dep_b0, ovf_a0, ovf_b0;
  logic [3:0] q_a0, q_b0;
  logic       t_a1, t_b1, dep_a1, dep_b1, ovf_a1, ovf_b1;
  logic [1:0] q_a1, q_b1;
`ifdef TC_INTERSECTION_CONFLICT_CHECK_EN
  logic       conf0, conf1;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  bit started = 0;

  always #5 CLK = ~CLK;

  tc_intersection_model #(.QDEPTH_W(4), .PASS_CYCLES(2), .YELLOW_PASS(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .ARR_A(ARR_A), .ARR_B(ARR_B), .L_A(L_A), .L_B(L_B),
    .T_A(t_a0), .T_B(t_b0), .Q_A(q_a0), .Q_B(q_b0),
    .DEP_A(dep_a0), .DEP_B(dep_b0), .OVF_A(ovf_a0), .OVF_B(ovf_b0)
`ifdef TC_INTERSECTION_CONFLICT_CHECK_EN
    , .CONFLICT(conf0)
`endif
  );

  tc_intersection_model #(.QDEPTH_W(2), .PASS_CYCLES(2), .YELLOW_PASS(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .ARR_A(ARR_A), .ARR_B(ARR_B), .L_A(L_A), .L_B(L_B),
    .T_A(t_a1), .T_B(t_b1), .Q_A(q_a1), .Q_B(q_b1),
    .DEP_A(dep_a1), .DEP_B(dep_b1), .OVF_A(ovf_a1), .OVF_B(ovf_b1)
`ifdef TC_INTERSECTION_CONFLICT_CHECK_EN
    , .CONFLICT(conf1)
`endif
  );

  // ---------------- behavioural model ----------------
  function automatic int cfg_qmax(input int d); return (d == 0) ? 15 : 3; endfunction
  function automatic int cfg_pass(input int d); return 2; endfunction
  function automatic bit cfg_yp(input int d);   return (d == 1); endfunction

  int m_q[2][2];
  int m_streak[2][2];     // consecutive edges with the street moving and non-empty
  bit m_go[2][2];
  bit m_dep[2][2];
  bit m_ovf[2][2];
  bit m_conf;

  function automatic bit nonred(input logic [2:0] l); return (l == G) || (l == Y); endfunction
  function automatic bit legal(input logic [2:0] l);  return (l == G) || (l == Y) || (l == R); endfunction

  task automatic model_step(input int d, input int s, input bit arr, input logic [2:0] l);
    bit elig, dep;
    if (RESET) begin
      m_q[d][s] = 0; m_streak[d][s] = 0; m_go[d][s] = 0; m_dep[d][s] = 0; m_ovf[d][s] = 0;
    end else begin
      elig = m_go[d][s] && (m_q[d][s] > 0);
      m_streak[d][s] = elig ? m_streak[d][s] + 1 : 0;
      dep = elig && (m_streak[d][s] % cfg_pass(d) == 0);
      if (arr && !dep) begin
        if (m_q[d][s] == cfg_qmax(d)) m_ovf[d][s] = 1;
        else                          m_q[d][s]++;
      end else if (dep && !arr) begin
        m_q[d][s]--;
      end
      m_dep[d][s] = dep;
      m_go[d][s] = (l == G) || (cfg_yp(d) && l == Y);
    end
  endtask

  always @(posedge CLK) begin
    started = 1;
    for (int d = 0; d < 2; d++) begin
      model_step(d, 0, ARR_A, L_A);
      model_step(d, 1, ARR_B, L_B);
    end
    if (RESET) m_conf = 0;
    else m_conf = m_conf | (nonred(L_A) && nonred(L_B)) | !legal(L_A) | !legal(L_B);
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_street(input int d, input int s, input logic t, input logic [31:0] q,
                            input logic dep, input logic ovf);
    string nm;
    nm = $sformatf("dut%0d_%s", d, (s == 0) ? "A" : "B");
    chk({nm, "_Q"},   q,   m_q[d][s]);
    chk({nm, "_T"},   {31'd0, t},   int'(m_q[d][s] != 0));
    chk({nm, "_DEP"}, {31'd0, dep}, int'(m_dep[d][s]));
    chk({nm, "_OVF"}, {31'd0, ovf}, int'(m_ovf[d][s]));
  endtask

  always @(negedge CLK) begin
    if (started) begin
      cmp_street(0, 0, t_a0, {28'd0, q_a0}, dep_a0, ovf_a0);
      cmp_street(0, 1, t_b0, {28'd0, q_b0}, dep_b0, ovf_b0);
      cmp_street(1, 0, t_a1, {30'd0, q_a1}, dep_a1, ovf_a1);
      cmp_street(1, 1, t_b1, {30'd0, q_b1}, dep_b1, ovf_b1);
`ifdef TC_INTERSECTION_CONFLICT_CHECK_EN
      chk("dut0_CONFLICT", {31'd0, conf0}, int'(m_conf));
      chk("dut1_CONFLICT", {31'd0, conf1}, int'(m_conf));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rst, input bit aa, input bit ab,
                     input logic [2:0] la, input logic [2:0] lb);
    RESET = rst; ARR_A = aa; ARR_B = ab; L_A = la; L_B = lb;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] la, lb;
    // Reset with an arrival present: it must be ignored
    cyc(1, 1, 1, R, R);
    cyc(1, 1, 0, R, R);
    chk("lit_reset_QA", {28'd0, q_a0}, 0);
    chk("lit_reset_TA", {31'd0, t_a0}, 0);

    // Three arrivals on red
    repeat (3) cyc(0, 1, 0, R, R);
    chk("lit_arr3_QA",  {28'd0, q_a0}, 3);
    chk("lit_arr3_TA",  {31'd0, t_a0}, 1);
    chk("lit_arr3_DEP", {31'd0, dep_a0}, 0);
    chk("lit_arr3_TB",  {31'd0, t_b0}, 0);

    // Green on A: departures at GO+2, +4, +6
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, G, R);
      if (k == 2) chk("lit_go2_DEP", {31'd0, dep_a0}, 0);
      if (k == 3) begin
        chk("lit_go3_DEP", {31'd0, dep_a0}, 1);
        chk("lit_go3_QA",  {28'd0, q_a0}, 2);
      end
      if (k == 7) begin
        chk("lit_go7_DEP", {31'd0, dep_a0}, 1);
        chk("lit_go7_QA",  {28'd0, q_a0}, 0);
        chk("lit_go7_TA",  {31'd0, t_a0}, 0);
      end
    end

    // Street B: 4 arrivals on red overflow the 2-bit queue
    repeat (4) cyc(0, 0, 1, R, R);
    chk("lit_ovf_QB1",  {30'd0, q_b1}, 3);
    chk("lit_ovf_OVF1", {31'd0, ovf_b1}, 1);
    chk("lit_ovf_QB0",  {28'd0, q_b0}, 4);
    chk("lit_ovf_OVF0", {31'd0, ovf_b0}, 0);
    cyc(0, 0, 0, R, G);
    cyc(0, 0, 0, R, G);
    cyc(0, 0, 1, R, G);  // arrival together with the first departure
    chk("lit_full_dep_QB1",  {30'd0, q_b1}, 3);
    chk("lit_full_dep_DEP1", {31'd0, dep_b1}, 1);
    chk("lit_full_dep_QB0",  {28'd0, q_b0}, 4);
    repeat (10) cyc(0, 0, 0, R, G);
    cyc(0, 0, 0, R, R);

    // Yellow with two waiting cars
    repeat (2) cyc(0, 1, 0, R, R);
    repeat (3) cyc(0, 0, 0, Y, R);
    chk("lit_yel_DEP0", {31'd0, dep_a0}, 0);
    chk("lit_yel_QA0",  {28'd0, q_a0}, 2);
    chk("lit_yel_DEP1", {31'd0, dep_a1}, 1);
    chk("lit_yel_QA1",  {30'd0, q_a1}, 1);
    repeat (3) cyc(0, 0, 0, Y, R);
    cyc(0, 0, 0, R, R);

    // Reset in the middle of a drain
    repeat (3) cyc(0, 1, 0, R, R);
    chk("lit_pre_rst_QA0", {28'd0, q_a0}, 5);
    repeat (3) cyc(0, 0, 0, G, R);
    cyc(1, 1, 0, G, R);
    chk("lit_rst_QA0",  {28'd0, q_a0}, 0);
    chk("lit_rst_DEP0", {31'd0, dep_a0}, 0);
    chk("lit_rst_OVF0", {31'd0, ovf_b0}, 0);
    chk("lit_rst_QA1",  {30'd0, q_a1}, 0);
    cyc(0, 0, 0, R, R);

    // Illegal light code acts as red
    repeat (2) cyc(0, 1, 0, R, R);
    repeat (4) cyc(0, 0, 0, 3'b011, R);
    chk("lit_bad_QA0",  {28'd0, q_a0}, 2);
    chk("lit_bad_DEP0", {31'd0, dep_a0}, 0);

`ifdef TC_INTERSECTION_CONFLICT_CHECK_EN
    cyc(1, 0, 0, R, R);
    cyc(0, 0, 0, G, Y);
    cyc(0, 0, 0, R, R);
    cyc(0, 0, 0, R, R);
    chk("lit_conf_sticky", {31'd0, conf0}, 1);
    cyc(1, 0, 0, R, R);
    chk("lit_conf_reset", {31'd0, conf0}, 0);
    cyc(0, 0, 0, 3'b011, R);
    chk("lit_conf_illegal", {31'd0, conf0}, 1);
`endif

    // Mixed traffic: lights held for a few cycles, random arrivals
    la = R; lb = R;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 7))
          0, 1, 2: la = G;
          3:       la = Y;
          4:       la = 3'b110;
          default: la = R;
        endcase
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 7))
          0, 1, 2: lb = G;
          3:       lb = Y;
          4:       lb = 3'b000;
          default: lb = R;
        endcase
      end
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0), la, lb);
    end

    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
